// File: rtl/grf_dumper_pkg.sv
// Shared types and constants for the general register file dumper.
// States, register count and index width of the default file.
package grf_dump_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND,
        DONE
    } grf_state_e;

    localparam int GRF_NREGS = 32;
    localparam int GRF_AW    = 5;

endpackage

// File: rtl/grf_dumper_if.sv
// Output beat stream of the dumper: one (index, value) per handshake.
// Master drives valid and payload, slave drives ready.
interface grf_dumper_if
    import grf_dump_pkg::*;
#(
    parameter int AW = GRF_AW,
    parameter int DW = 32
);

    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_idx;
    logic [DW-1:0] out_data;

    modport master (
        output out_valid,
        output out_idx,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_idx,
        input  out_data,
        output out_ready
    );

endinterface

// File: rtl/grf_dumper.sv
// Walks a spare register file read port low to high and streams
// each register as an (index, value) beat; pulses done at the end.
module grf_dumper
    import grf_dump_pkg::*;
#(
    parameter int NREGS     = GRF_NREGS,
    parameter int AW        = GRF_AW,
    parameter int DW        = 32,
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          only_nonzero,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          busy,
    output logic          done,
    grf_dumper_if.master  out_if
);

    grf_state_e    state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          nz_q, nz_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [DW-1:0] data_q, data_d;
    logic          last;

    // Increment is suppressed on the last index so ptr never wraps.
    assign last = (ptr_q == AW'(NREGS - 1));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        nz_d    = nz_q;
        idx_d   = idx_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                ptr_d = '0;
                if (start) begin
                    ptr_d   = SKIP_ZERO ? AW'(1) : '0;
                    nz_d    = only_nonzero;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (nz_q && (rd_data == '0)) begin
                    if (last) state_d = DONE;
                    else      ptr_d   = ptr_q + AW'(1);
                end else begin
                    idx_d   = ptr_q;
                    data_d  = rd_data;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (out_if.out_ready) begin
                    if (last) begin
                        state_d = DONE;
                    end else begin
                        ptr_d   = ptr_q + AW'(1);
                        state_d = FETCH;
                    end
                end
            end
            DONE: begin
                ptr_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            nz_q    <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            nz_q    <= nz_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    assign rd_addr          = ptr_q;
    assign busy             = (state_q != IDLE);
    assign done             = (state_q == DONE);
    assign out_if.out_valid = (state_q == SEND);
    assign out_if.out_idx   = idx_q;
    assign out_if.out_data  = data_q;

endmodule

// File: tb/tb_grf_dumper.sv
// Self-checking bench for grf_dumper: table of dump scenarios with a
// beat scoreboard, plus backpressure and mid-dump reset sequences.
module tb_grf_dumper;
    import grf_dump_pkg::*;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int N  = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          only_nonzero = 1'b0;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          done;
    logic [DW-1:0] rf [N];

    grf_dumper_if #(.AW(AW), .DW(DW)) oif ();

    grf_dumper #(
        .NREGS(N), .AW(AW), .DW(DW), .SKIP_ZERO(1'b1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .only_nonzero (only_nonzero),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .busy         (busy),
        .done         (done),
        .out_if       (oif.master)
    );

    always #5 clk = ~clk;
    assign rd_data = rf[rd_addr];

    typedef struct {
        int mode;
        bit nz;
        bit rnd_ready;
        bit start_busy;
        int exp_beats;
        int exp_done;
    } vec_t;

    typedef struct {
        logic [AW-1:0] idx;
        logic [DW-1:0] data;
    } beat_t;

    beat_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fill(input int mode);
        for (int i = 0; i < N; i++) begin
            case (mode)
                0: rf[i] = 32'h100 + i;
                3: rf[i] = ($urandom_range(0, 2) == 0) ? '0 : $urandom;
                default: rf[i] = '0;
            endcase
        end
        if (mode == 1) begin
            rf[3]  = 32'hDEADBEEF;
            rf[31] = 32'h00000001;
        end
        // index 0 must never show up in a dump
        rf[0] = 32'hFFFF_FFFF;
    endtask

    task automatic run_dump(input vec_t v, input string tag);
        int n, beats, dones, done_n;
        bit seen_valid, pend;
        logic [AW-1:0] p_idx;
        logic [DW-1:0] p_data;
        beat_t b;
        fill(v.mode);
        sb.delete();
        for (int i = 1; i < N; i++)
            if (!(v.nz && rf[i] == '0))
                sb.push_back('{idx: AW'(i), data: rf[i]});
        beats = 0; dones = 0; done_n = 0;
        seen_valid = 0; pend = 0; p_idx = '0; p_data = '0;
        @(negedge clk);
        only_nonzero = v.nz;
        start = 1'b1;
        oif.out_ready = 1'b1;
        @(posedge clk);
        n = 1;
        @(negedge clk);
        only_nonzero = ~v.nz;
        chk({tag, " busy_after_start"}, 64'(busy), 64'd1);
        while (n < 2000 && !(dones > 0 && n >= done_n + 3)) begin
            start = 1'b0;
            if (v.start_busy && n == 20) start = 1'b1;
            oif.out_ready = v.rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pend) begin
                chk({tag, " hold_valid"}, 64'(oif.out_valid), 64'd1);
                chk({tag, " hold_idx"}, 64'(oif.out_idx), 64'(p_idx));
                chk({tag, " hold_data"}, 64'(oif.out_data), 64'(p_data));
            end
            pend = 0;
            if (oif.out_valid) begin
                if (!seen_valid && v.mode == 0)
                    chk({tag, " first_valid_cycle"}, 64'(n), 64'd2);
                seen_valid = 1;
                if (oif.out_ready) begin
                    beats++;
                    if (sb.size() == 0) begin
                        chk({tag, " extra_beat"}, 64'(oif.out_idx), 64'hFFFF);
                    end else begin
                        b = sb.pop_front();
                        chk({tag, " beat_idx"}, 64'(oif.out_idx), 64'(b.idx));
                        chk({tag, " beat_data"}, 64'(oif.out_data), 64'(b.data));
                    end
                end else begin
                    pend = 1;
                    p_idx = oif.out_idx;
                    p_data = oif.out_data;
                end
            end
            if (done) begin
                dones++;
                done_n = n;
                if (v.start_busy) start = 1'b1;
            end
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        oif.out_ready = 1'b1;
        if (v.exp_beats >= 0)
            chk({tag, " beat_count"}, 64'(beats), 64'(v.exp_beats));
        chk({tag, " leftover_beats"}, 64'(sb.size()), 64'd0);
        chk({tag, " done_count"}, 64'(dones), 64'd1);
        if (v.exp_done > 0)
            chk({tag, " done_cycle"}, 64'(done_n), 64'(v.exp_done));
        chk({tag, " idle_busy"}, 64'(busy), 64'd0);
        chk({tag, " idle_addr"}, 64'(rd_addr), 64'd0);
    endtask

    task automatic wait_beat(input logic [AW-1:0] idx, input string tag);
        int k;
        k = 0;
        while (!(oif.out_valid && oif.out_idx == idx) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk({tag, " reach_beat"}, 64'(k < 200), 64'd1);
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (!done && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk({tag, " reach_done"}, 64'(done), 64'd1);
        @(negedge clk);
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{0, 1'b0, 1'b0, 1'b0, 31, 63};
        vecs[1] = '{1, 1'b1, 1'b0, 1'b0, 2, 34};
        vecs[2] = '{2, 1'b1, 1'b0, 1'b0, 0, 32};
        vecs[3] = '{0, 1'b0, 1'b0, 1'b1, 31, 63};
        vecs[4] = '{3, 1'b1, 1'b1, 1'b0, -1, 0};
        vecs[5] = '{3, 1'b0, 1'b1, 1'b0, 31, 0};
        vecs[6] = '{0, 1'b1, 1'b1, 1'b1, 31, 0};

        oif.out_ready = 1'b1;
        fill(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(oif.out_valid), 64'd0);
        chk("rst_idx", 64'(oif.out_idx), 64'd0);
        chk("rst_data", 64'(oif.out_data), 64'd0);
        chk("rst_addr", 64'(rd_addr), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int t = 0; t < 7; t++)
            run_dump(vecs[t], $sformatf("vec%0d", t));

        // backpressure on the idx 2 beat
        fill(0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_beat(AW'(2), "bp");
        oif.out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", 64'(oif.out_valid), 64'd1);
            chk("bp_idx", 64'(oif.out_idx), 64'd2);
            chk("bp_data", 64'(oif.out_data), 64'h102);
            chk("bp_addr", 64'(rd_addr), 64'd2);
        end
        oif.out_ready = 1'b1;
        @(negedge clk);
        wait_beat(AW'(3), "bp_next");
        chk("bp_next_data", 64'(oif.out_data), 64'h103);
        wait_done("bp");

        // reset while the idx 7 beat is pending
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_beat(AW'(7), "rst_mid");
        oif.out_ready = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_valid", 64'(oif.out_valid), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_done", 64'(done), 64'd0);
        chk("rst_mid_idx", 64'(oif.out_idx), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        oif.out_ready = 1'b1;
        @(negedge clk);
        chk("rst_mid_no_done", 64'(done), 64'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("restart_valid", 64'(oif.out_valid), 64'd1);
        chk("restart_idx", 64'(oif.out_idx), 64'd1);
        chk("restart_data", 64'(oif.out_data), 64'h101);
        wait_done("restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
